// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: bundles the raw machine inputs and the controller outputs
// (display driver inputs, dispense strobe, change-return handshake).
//   master - drives buttons/coins/power, observes controller outputs
//   slave  - the controller side
interface vend_ctrl_if;
    logic       power_sw;
    logic       start_btn;
    logic       coin_half;
    logic       coin_1;
    logic       coin_5;
    logic       coin_10;
    logic [1:0] price_sel;
    logic       buy_btn;
    logic       cancel_btn;

    logic       light;
    logic       op_start;
    logic [9:0] coin_val;
    logic       dispense;
    logic [9:0] change_out;
    logic       change_valid;
    logic       coin_reject;
    logic       short_funds;

    modport master (
        output power_sw, start_btn, coin_half, coin_1, coin_5, coin_10,
               price_sel, buy_btn, cancel_btn,
        input  light, op_start, coin_val, dispense, change_out,
               change_valid, coin_reject, short_funds
    );

    modport slave (
        input  power_sw, start_btn, coin_half, coin_1, coin_5, coin_10,
               price_sel, buy_btn, cancel_btn,
        output light, op_start, coin_val, dispense, change_out,
               change_valid, coin_reject, short_funds
    );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine transaction controller feeding the 8-digit
// seven-segment display driver. Credit is held in half-yuan units.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - vend_ctrl_if.slave: raw buttons/coins/power in; light, op_start,
//           coin_val, dispense, change_out/change_valid, coin_reject and
//           short_funds out (all registered).
module vend_ctrl #(
    parameter int PRICE0       = 5,
    parameter int PRICE1       = 7,
    parameter int PRICE2       = 10,
    parameter int PRICE3       = 20,
    parameter int MAX_VAL      = 999,
    parameter int DISP_CYCLES  = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic      clk,
    input  logic      reset,
    vend_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_HELLO   = 3'd1,
        S_COLLECT = 3'd2,
        S_VEND    = 3'd3,
        S_REFUND  = 3'd4
    } state_t;

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    // Counter only needs to hold DISP_CYCLES-1.
    localparam int DISP_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    localparam int B_START  = 0;
    localparam int B_HALF   = 1;
    localparam int B_C1     = 2;
    localparam int B_C5     = 3;
    localparam int B_C10    = 4;
    localparam int B_BUY    = 5;
    localparam int B_CANCEL = 6;

    // Inputs are registered once before edge detection, which gives the
    // one-cycle input-to-decision latency and keeps price_sel aligned with
    // the buy edge it belongs to.
    logic [6:0]        in_d, in_q, prev_q, edge_w;
    logic              pwr_q;
    logic [1:0]        sel_q;

    state_t            state_q, state_d;
    logic [DISP_W-1:0] disp_cnt_q, disp_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [9:0]        credit_d;
    logic [9:0]        price;
    logic [9:0]        coin_sum;
    logic [10:0]       coin_total;
    logic              reject_ev, short_ev;

    logic              light_q, light_d;
    logic              op_start_q, op_start_d;
    logic [9:0]        coin_val_q, coin_val_d;
    logic              dispense_q, dispense_d;
    logic [9:0]        change_out_q, change_out_d;
    logic              change_valid_q, change_valid_d;
    logic              coin_reject_q, coin_reject_d;
    logic              short_funds_q, short_funds_d;

    always_comb begin
        in_d = {bus.cancel_btn, bus.buy_btn, bus.coin_10, bus.coin_5,
                bus.coin_1, bus.coin_half, bus.start_btn};
    end

    for (genvar gi = 0; gi < 7; gi++) begin : g_edge
        assign edge_w[gi] = in_q[gi] & ~prev_q[gi];
    end

    always_comb begin
        case (sel_q)
            2'd0:    price = 10'(PRICE0);
            2'd1:    price = 10'(PRICE1);
            2'd2:    price = 10'(PRICE2);
            default: price = 10'(PRICE3);
        endcase
    end

    // All coin edges of one cycle are accepted or refused together; the
    // 11-bit total can never wrap.
    always_comb begin
        coin_sum = 10'(edge_w[B_HALF])
                 + (edge_w[B_C1]  ? 10'd2  : 10'd0)
                 + (edge_w[B_C5]  ? 10'd10 : 10'd0)
                 + (edge_w[B_C10] ? 10'd20 : 10'd0);
        coin_total = {1'b0, coin_val_q} + {1'b0, coin_sum};
    end

    // State and output registers. During reset the edge-detect history
    // tracks the live inputs so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q           <= in_d;
            prev_q         <= in_d;
            pwr_q          <= bus.power_sw;
            sel_q          <= bus.price_sel;
            state_q        <= S_OFF;
            disp_cnt_q     <= '0;
            idle_q         <= '0;
            light_q        <= 1'b0;
            op_start_q     <= 1'b0;
            coin_val_q     <= '0;
            dispense_q     <= 1'b0;
            change_out_q   <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            short_funds_q  <= 1'b0;
        end else begin
            in_q           <= in_d;
            prev_q         <= in_q;
            pwr_q          <= bus.power_sw;
            sel_q          <= bus.price_sel;
            state_q        <= state_d;
            disp_cnt_q     <= disp_cnt_d;
            idle_q         <= idle_d;
            light_q        <= light_d;
            op_start_q     <= op_start_d;
            coin_val_q     <= coin_val_d;
            dispense_q     <= dispense_d;
            change_out_q   <= change_out_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            short_funds_q  <= short_funds_d;
        end
    end

    // Next-state logic. Inside COLLECT the if-chain order encodes the
    // priority power loss > cancel > buy > coins > idle timing.
    always_comb begin
        state_d    = state_q;
        credit_d   = coin_val_q;
        disp_cnt_d = disp_cnt_q;
        idle_d     = '0;
        reject_ev  = 1'b0;
        short_ev   = 1'b0;
        case (state_q)
            S_OFF: begin
                credit_d = '0;
                if (pwr_q) state_d = S_HELLO;
            end
            S_HELLO: begin
                credit_d = '0;
                if (!pwr_q)                state_d = S_OFF;
                else if (edge_w[B_START])  state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (!pwr_q) begin
                    state_d = (coin_val_q != '0) ? S_REFUND : S_OFF;
                end else if (edge_w[B_CANCEL]) begin
                    state_d = (coin_val_q != '0) ? S_REFUND : S_HELLO;
                end else if (edge_w[B_BUY]) begin
                    if (coin_val_q >= price) begin
                        credit_d   = coin_val_q - price;
                        state_d    = S_VEND;
                        disp_cnt_d = DISP_W'(DISP_CYCLES - 1);
                    end else begin
                        short_ev = 1'b1;
                    end
                end else if (coin_sum != '0) begin
                    if (coin_total <= 11'(MAX_VAL)) credit_d  = coin_total[9:0];
                    else                            reject_ev = 1'b1;
                end else if ((coin_val_q == '0) && (edge_w == '0)) begin
                    if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) state_d = S_HELLO;
                    else                                      idle_d  = idle_q + IDLE_W'(1);
                end
            end
            S_VEND: begin
                // Power loss is only acted on once the item has been released.
                if (disp_cnt_q == '0) begin
                    if (pwr_q)                  state_d = S_COLLECT;
                    else if (coin_val_q != '0)  state_d = S_REFUND;
                    else                        state_d = S_OFF;
                end else begin
                    disp_cnt_d = disp_cnt_q - DISP_W'(1);
                end
            end
            S_REFUND: begin
                credit_d = '0;
                state_d  = pwr_q ? S_HELLO : S_OFF;
            end
            default: begin
                credit_d = '0;
                state_d  = S_OFF;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        light_d        = (state_d != S_OFF);
        op_start_d     = (state_d == S_COLLECT) || (state_d == S_VEND) ||
                         (state_d == S_REFUND);
        dispense_d     = (state_d == S_VEND);
        change_valid_d = (state_d == S_REFUND);
        // Entering REFUND the credit register still holds the amount owed.
        change_out_d   = change_valid_d ? coin_val_q : '0;
        coin_val_d     = change_valid_d ? '0 : credit_d;
        coin_reject_d  = reject_ev;
        short_funds_d  = short_ev;
    end

    assign bus.light        = light_q;
    assign bus.op_start     = op_start_q;
    assign bus.coin_val     = coin_val_q;
    assign bus.dispense     = dispense_q;
    assign bus.change_out   = change_out_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.short_funds  = short_funds_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl. Stimulus pushes the expected
// output events into a queue; a negedge monitor turns DUT output activity
// into events (level changes, pulses, dispense run length) and checks them
// in order against the queue.
module tb_vend_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_ctrl_if bus();

    vend_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int K_LIGHT  = 0;
    localparam int K_OP     = 1;
    localparam int K_CREDIT = 2;
    localparam int K_REJ    = 3;
    localparam int K_SHORT  = 4;
    localparam int K_CHANGE = 5;
    localparam int K_DISP   = 6;

    localparam logic [6:0] M_START  = 7'b0000001;
    localparam logic [6:0] M_HALF   = 7'b0000010;
    localparam logic [6:0] M_C1     = 7'b0000100;
    localparam logic [6:0] M_C5     = 7'b0001000;
    localparam logic [6:0] M_C10    = 7'b0010000;
    localparam logic [6:0] M_BUY    = 7'b0100000;
    localparam logic [6:0] M_CANCEL = 7'b1000000;

    typedef struct {
        int kind;
        int val;
        int earliest;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  cyc      = 0;
    int  deadline = 32'h7fffffff;
    bit  phase1   = 1'b0;
    bit  mon_en   = 1'b0;
    logic       p_light, p_op;
    logic [9:0] p_credit;
    int  disp_run = 0;

    function automatic string kname(int k);
        case (k)
            K_LIGHT:  return "light";
            K_OP:     return "op_start";
            K_CREDIT: return "coin_val";
            K_REJ:    return "coin_reject";
            K_SHORT:  return "short_funds";
            K_CHANGE: return "change";
            K_DISP:   return "dispense_len";
            default:  return "?";
        endcase
    endfunction

    // Called only from the monitor process.
    task automatic see(int k, int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got %s=%0d, nothing expected", cyc, kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event cyc=%0d got %s=%0d want %s=%0d", cyc, kname(k), v, kname(e.kind), e.val);
            end else if (cyc < e.earliest) begin
                errors++;
                $display("FAIL too_early %s=%0d at cyc=%0d want cyc>=%0d", kname(k), v, cyc, e.earliest);
            end else begin
                $display("ok   cyc=%0d %s=%0d", cyc, kname(k), v);
            end
        end
    endtask

    task automatic chk_rst(string n, int got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL reset_%s got %0d want 0", n, got);
        end else begin
            $display("ok   reset_%s=0", n);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (phase1 && !mon_en) begin
            chk_rst("light",        int'(bus.light));
            chk_rst("op_start",     int'(bus.op_start));
            chk_rst("coin_val",     int'(bus.coin_val));
            chk_rst("dispense",     int'(bus.dispense));
            chk_rst("change_out",   int'(bus.change_out));
            chk_rst("change_valid", int'(bus.change_valid));
            chk_rst("coin_reject",  int'(bus.coin_reject));
            chk_rst("short_funds",  int'(bus.short_funds));
            p_light  = 1'b0;
            p_op     = 1'b0;
            p_credit = 10'd0;
            mon_en   = 1'b1;
        end else if (mon_en) begin
            if (bus.light !== p_light) begin
                see(K_LIGHT, int'(bus.light));
                p_light = bus.light;
            end
            if (bus.op_start !== p_op) begin
                see(K_OP, int'(bus.op_start));
                p_op = bus.op_start;
            end
            if (bus.coin_val !== p_credit) begin
                see(K_CREDIT, int'(bus.coin_val));
                p_credit = bus.coin_val;
            end
            if (bus.coin_reject  !== 1'b0) see(K_REJ, 0);
            if (bus.short_funds  !== 1'b0) see(K_SHORT, 0);
            if (bus.change_valid !== 1'b0) see(K_CHANGE, int'(bus.change_out));
            if (bus.dispense === 1'b1) begin
                disp_run++;
            end else if (disp_run > 0) begin
                see(K_DISP, disp_run);
                disp_run = 0;
            end
            if (exp_q.size() != 0 && cyc > deadline) begin
                checks++;
                errors++;
                $display("FAIL timeout cyc=%0d still waiting for %s=%0d (%0d pending)",
                         cyc, kname(exp_q[0].kind), exp_q[0].val, exp_q.size());
                exp_q.delete();
            end
        end
    end

    task automatic ex(int k, int v, int earliest = 0);
        ev_t e;
        e.kind     = k;
        e.val      = v;
        e.earliest = earliest;
        exp_q.push_back(e);
    endtask

    // Wait until the monitor has consumed every expected event; the monitor
    // flushes the queue (and reports) once the deadline passes.
    task automatic drain(int budget);
        deadline = cyc + budget;
        for (int i = 0; i < budget + 5 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        deadline = 32'h7fffffff;
    endtask

    task automatic set_in(logic [6:0] m);
        bus.start_btn  = m[0];
        bus.coin_half  = m[1];
        bus.coin_1     = m[2];
        bus.coin_5     = m[3];
        bus.coin_10    = m[4];
        bus.buy_btn    = m[5];
        bus.cancel_btn = m[6];
    endtask

    task automatic pulse(logic [6:0] m);
        set_in(m);
        repeat (2) @(negedge clk);
        set_in(7'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.power_sw  = 1'b0;
        bus.price_sel = 2'd0;
        set_in(7'd0);
        repeat (3) @(posedge clk);
        phase1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Power up, start, 5 + 0.5 yuan -> 11.
        ex(K_LIGHT, 1);  bus.power_sw = 1'b1; drain(10);
        ex(K_OP, 1);     pulse(M_START);      drain(10);
        ex(K_CREDIT, 11); pulse(M_C5 | M_HALF); drain(10);

        // Buy item 2 (10) -> 1, four-cycle dispense.
        bus.price_sel = 2'd2;
        ex(K_CREDIT, 1); ex(K_DISP, 4); pulse(M_BUY); drain(20);

        // Credit 3, item 3 (20) -> short funds, credit unchanged.
        ex(K_CREDIT, 3); pulse(M_C1); drain(10);
        bus.price_sel = 2'd3;
        ex(K_SHORT, 0);  pulse(M_BUY); drain(10);

        // Climb to 990.
        for (int i = 1; i <= 49; i++) begin
            ex(K_CREDIT, 3 + 20 * i); pulse(M_C10); drain(10);
        end
        for (int i = 1; i <= 3; i++) begin
            ex(K_CREDIT, 983 + 2 * i); pulse(M_C1); drain(10);
        end
        ex(K_CREDIT, 990); pulse(M_HALF); drain(10);

        // Ceiling: 990+20 refused, 0.5 accepted, exactly 999 accepted.
        ex(K_REJ, 0);      pulse(M_C10);  drain(10);
        ex(K_CREDIT, 991); pulse(M_HALF); drain(10);
        for (int i = 1; i <= 4; i++) begin
            ex(K_CREDIT, 991 + 2 * i); pulse(M_C1); drain(10);
        end
        ex(K_REJ, 0); pulse(M_HALF); drain(10);
        ex(K_REJ, 0); pulse(M_HALF | M_C1 | M_C5 | M_C10); drain(10);

        // Purchases at each remaining price.
        bus.price_sel = 2'd3;
        ex(K_CREDIT, 979); ex(K_DISP, 4); pulse(M_BUY); drain(20);
        bus.price_sel = 2'd0;
        ex(K_CREDIT, 974); ex(K_DISP, 4); pulse(M_BUY); drain(20);
        bus.price_sel = 2'd1;
        ex(K_CREDIT, 967); ex(K_DISP, 4); pulse(M_BUY); drain(20);

        // Buy beats a coin in the same cycle; the coin is dropped.
        bus.price_sel = 2'd0;
        ex(K_CREDIT, 962); ex(K_DISP, 4); pulse(M_BUY | M_C10); drain(20);

        // Cancel beats buy: refund, back to HELLO, no dispense.
        ex(K_CREDIT, 0); ex(K_CHANGE, 962); ex(K_OP, 0);
        pulse(M_CANCEL | M_BUY); drain(20);

        // HELLO ignores coins/buy/cancel.
        pulse(M_C1 | M_BUY | M_CANCEL); drain(10);

        // Cancel at zero credit goes straight to HELLO.
        ex(K_OP, 1); pulse(M_START);  drain(10);
        ex(K_OP, 0); pulse(M_CANCEL); drain(10);
        ex(K_OP, 1); pulse(M_START);  drain(10);

        // Credit 6, then power loss -> refund 6, then OFF.
        for (int i = 1; i <= 3; i++) begin
            ex(K_CREDIT, 2 * i); pulse(M_C1); drain(10);
        end
        ex(K_CREDIT, 0); ex(K_CHANGE, 6); ex(K_LIGHT, 0); ex(K_OP, 0);
        bus.power_sw = 1'b0; drain(20);

        // Idle timeout at zero credit: op_start falls after ~1000 cycles.
        ex(K_LIGHT, 1); bus.power_sw = 1'b1; drain(10);
        ex(K_OP, 1);    pulse(M_START);      drain(10);
        ex(K_OP, 0, cyc + 990); drain(1200);

        // Power loss during VEND: dispense completes, refund 5, then OFF.
        ex(K_OP, 1);      pulse(M_START); drain(10);
        ex(K_CREDIT, 10); pulse(M_C5);    drain(10);
        bus.price_sel = 2'd0;
        ex(K_CREDIT, 5); ex(K_CREDIT, 0); ex(K_CHANGE, 5); ex(K_DISP, 4);
        ex(K_LIGHT, 0);  ex(K_OP, 0);
        pulse(M_BUY);
        bus.power_sw = 1'b0;
        drain(30);

        // Reset mid-session: credit lost with no refund pulse.
        ex(K_LIGHT, 1);  bus.power_sw = 1'b1; drain(10);
        ex(K_OP, 1);     pulse(M_START);      drain(10);
        ex(K_CREDIT, 2); pulse(M_C1);         drain(10);
        ex(K_LIGHT, 0); ex(K_OP, 0); ex(K_CREDIT, 0);
        reset = 1'b1; drain(10);
        ex(K_LIGHT, 1); reset = 1'b0; drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
